// File: rtl/decode_stage.sv
`default_nettype none
//============================================================================
// Module  : decode_stage
// Brief   : Registered RV32I decode stage with valid/ready handshake, flush
//           and a wrapping accepted-instruction counter.
// Revision: 1.0 - initial release
//============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [9:0]       opClass,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic             funct7b5,
    output logic [XLEN-1:0]  imm,
    output logic             regWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instrCount
);

    localparam logic [6:0] c_OP_ALUREG = 7'b0110011;
    localparam logic [6:0] c_OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // Classes that write rd: ALUreg, ALUimm, JALR, JAL, AUIPC, LUI, Load
    localparam logic [9:0] c_WRITES_RD = 10'b0011111011;

    logic             r_outValid;
    logic [XLEN-1:0]  r_outPc;
    logic [9:0]       r_opClass;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic [XLEN-1:0]  r_imm;
    logic             r_regWrite;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instrCount;

    logic             w_accept;
    logic [9:0]       w_opClass;
    logic             w_illegal;
    logic             w_regWrite;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_immI;
    logic [XLEN-1:0]  w_immS;
    logic [XLEN-1:0]  w_immB;
    logic [XLEN-1:0]  w_immU;
    logic [XLEN-1:0]  w_immJ;

    assign in_ready = !reset && (!r_outValid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    assign w_immI = XLEN'($signed(instr[31:20]));
    assign w_immS = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign w_immB = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign w_immU = XLEN'($signed({instr[31:12], 12'b0}));
    assign w_immJ = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    always_comb begin
        w_opClass = '0;
        w_illegal = 1'b0;
        w_imm     = '0;
        case (instr[6:0])
            c_OP_ALUREG: w_opClass[0] = 1'b1;
            c_OP_ALUIMM: begin w_opClass[1] = 1'b1; w_imm = w_immI; end
            c_OP_BRANCH: begin w_opClass[2] = 1'b1; w_imm = w_immB; end
            c_OP_JALR:   begin w_opClass[3] = 1'b1; w_imm = w_immI; end
            c_OP_JAL:    begin w_opClass[4] = 1'b1; w_imm = w_immJ; end
            c_OP_AUIPC:  begin w_opClass[5] = 1'b1; w_imm = w_immU; end
            c_OP_LUI:    begin w_opClass[6] = 1'b1; w_imm = w_immU; end
            c_OP_LOAD:   begin w_opClass[7] = 1'b1; w_imm = w_immI; end
            c_OP_STORE:  begin w_opClass[8] = 1'b1; w_imm = w_immS; end
            c_OP_SYSTEM: w_opClass[9] = 1'b1;
            default:     w_illegal = 1'b1;
        endcase
    end

    // An illegal opcode leaves opClass all-zero, so the mask alone suppresses it
    assign w_regWrite = (|(w_opClass & c_WRITES_RD)) && (instr[11:7] != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid   <= 1'b0;
            r_outPc      <= '0;
            r_opClass    <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_funct3     <= '0;
            r_funct7b5   <= 1'b0;
            r_imm        <= '0;
            r_regWrite   <= 1'b0;
            r_illegal    <= 1'b0;
            r_instrCount <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_outValid   <= 1'b1;
            r_outPc      <= pc;
            r_opClass    <= w_opClass;
            r_rd         <= instr[11:7];
            r_rs1        <= instr[19:15];
            r_rs2        <= instr[24:20];
            r_funct3     <= instr[14:12];
            r_funct7b5   <= instr[30];
            r_imm        <= w_imm;
            r_regWrite   <= w_regWrite;
            r_illegal    <= w_illegal;
            r_instrCount <= r_instrCount + CNT_W'(1);
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid  = r_outValid;
    assign out_pc     = r_outPc;
    assign opClass    = r_opClass;
    assign rd         = r_rd;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign funct3     = r_funct3;
    assign funct7b5   = r_funct7b5;
    assign imm        = r_imm;
    assign regWrite   = r_regWrite;
    assign illegal    = r_illegal;
    assign instrCount = r_instrCount;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of pc and imm; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 32, width of the accepted-instruction counter.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instr/pc valid
- in_ready  out  1  stage can accept
- instr  in  32  raw RV32I instruction
- pc  in  XLEN  address of instr
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- out_pc  out  XLEN  registered pc
- opClass  out  10  one-hot class; bit0 ALUreg, bit1 ALUimm, bit2 Branch, bit3 JALR, bit4 JAL, bit5 AUIPC, bit6 LUI, bit7 Load, bit8 Store, bit9 SYSTEM
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]
- funct3  out  3  instr[14:12]
- funct7b5  out  1  instr[30]
- imm  out  XLEN  sign-extended immediate
- regWrite  out  1  destination write enable
- illegal  out  1  unrecognised encoding
- instrCount  out  CNT_W  accepted-instruction count

Function
REQ-005 SHALL be a single registered stage: all outputs except in_ready come from flops loaded on accept.
REQ-006 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-007 SHALL accept when in_valid && in_ready && !flush; the bundle loads and out_valid is 1 next cycle (latency 1).
REQ-008 SHALL clear out_valid when out_ready && out_valid and no accept occurs in the same cycle; accept plus drain in one cycle gives back-to-back throughput of 1 per cycle.
REQ-009 SHALL hold every bundle output stable while out_valid && !out_ready.
REQ-010 SHALL, on flush, clear out_valid next cycle and refuse the same-cycle input (no count increment); flush has priority over accept and hold.
REQ-011 SHALL set opClass from instr[6:0]: 0110011, 0010011, 1100011, 1100111, 1101111, 0010111, 0110111, 0000011, 0100011, 1110011 map to bits 0 to 9.
REQ-012 SHALL set illegal=1 and opClass=0 when instr[6:0] matches none of these or instr[1:0]!=2'b11.
REQ-013 SHALL form imm by class, sign-extended from instr[31] to XLEN:
- I (ALUimm, JALR, Load): instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U (LUI, AUIPC): {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- SYSTEM, ALUreg or illegal: 0
REQ-014 SHALL set regWrite = (ALUreg|ALUimm|Load|LUI|AUIPC|JAL|JALR) && rd!=0 && !illegal.
REQ-015 SHALL increment instrCount by 1 per accept, wrapping modulo 2^CNT_W; illegal instructions are counted.
REQ-016 SHALL decode illegal instructions through the handshake normally; no stall or trap is raised in this block.

Reset
REQ-017 SHALL, while reset is high, force on the next edge out_valid=0, instrCount=0, opClass=0, regWrite=0, illegal=0, imm=0, out_pc=0, rd/rs1/rs2/funct3/funct7b5=0; reset has priority over flush and accept.
REQ-018 SHALL hold in_ready=0 while reset is high; reset mid-transfer discards the held bundle without handshake.

Verification
REQ-019 SHALL cover: instr=0x00500093, pc=0x100, out_ready=1 -> next cycle out_valid=1, opClass=0x002, rd=1, imm=5, regWrite=1, out_pc=0x100, instrCount=1.
REQ-020 SHALL cover: instr=0xFE000EE3 (beq x0,x0,-4), XLEN=32 -> opClass=0x004, imm=0xFFFFFFFC, regWrite=0; with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
REQ-021 SHALL cover: instr=0x0000006F (jal x0,0) -> opClass=0x010, regWrite=0 (rd=0); instr=0x00000000 -> illegal=1, opClass=0, imm=0.
REQ-022 SHALL cover: out_ready=0 for 3 cycles after valid -> in_ready=0 and outputs stable; out_ready=1 with new in_valid -> next bundle the following cycle, no bubble, count +1 per accept.
REQ-023 SHALL cover: flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instrCount unchanged; reset asserted while out_valid=1 -> all outputs zero next cycle.
REQ-024 SHALL cover: CNT_W=4, 17 accepts -> instrCount=1 (wrap).
